// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register forward/writeback latency counters
// drive decode stalls, fetch flush on redirect, and a saturating stall counter.
module hazard_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int REG_W    = 3,
    parameter int NUM_SRC  = 3,
    parameter int CNT_W    = 2,
    parameter int PERF_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [NUM_SRC*REG_W-1:0] id_src_reg,
    input  logic [NUM_SRC-1:0]       id_src_valid,
    input  logic [NUM_SRC-1:0]       id_src_early,
    input  logic [REG_W-1:0]         id_dst_reg,
    input  logic                     id_dst_valid,
    input  logic [CNT_W-1:0]         id_fwd_lat,
    input  logic [CNT_W-1:0]         id_wb_lat,
    input  logic                     pipe_hold,
    input  logic                     redirect,
    output logic                     stall_decode,
    output logic                     flush_fetch,
    output logic [NUM_REGS-1:0]      busy_map,
    output logic [PERF_W-1:0]        stall_count
);

    logic [CNT_W-1:0] fwd_cnt [NUM_REGS];
    logic [CNT_W-1:0] wb_cnt  [NUM_REGS];
    logic             hazard;
    logic             accept;

    // Early sources (branch condition, jump base) are read in decode and must wait
    // for writeback; all others only need the value to be forwardable to EX.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (id_src_valid[i]) begin
                if (id_src_early[i])
                    hazard = hazard | (wb_cnt[id_src_reg[i*REG_W +: REG_W]] != '0);
                else
                    hazard = hazard | (fwd_cnt[id_src_reg[i*REG_W +: REG_W]] != '0);
            end
        end
    end

    assign stall_decode = id_valid & ~redirect & hazard;
    assign flush_fetch  = redirect;
    assign accept       = id_valid & ~stall_decode & ~redirect & ~pipe_hold;

    always_comb begin
        busy_map = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++)
            busy_map[r] = (fwd_cnt[r] != '0) | (wb_cnt[r] != '0);
    end

    // A newly accepted writer replaces whatever countdown the register had.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                fwd_cnt[r] <= '0;
                wb_cnt[r]  <= '0;
            end
        end else if (!pipe_hold) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (accept && id_dst_valid && (id_dst_reg == REG_W'(r))) begin
                    fwd_cnt[r] <= id_fwd_lat;
                    wb_cnt[r]  <= id_wb_lat;
                end else begin
                    if (fwd_cnt[r] != '0) fwd_cnt[r] <= fwd_cnt[r] - 1'b1;
                    if (wb_cnt[r] != '0)  wb_cnt[r]  <= wb_cnt[r] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (stall_decode && !pipe_hold && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; inputs change 1ns after the rising edge,
// combinational outputs are checked 1ns later, registered state right after each edge.
module tb_hazard_scoreboard;

    localparam int PERF_W = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       id_valid;
    logic [8:0] id_src_reg;
    logic [2:0] id_src_valid;
    logic [2:0] id_src_early;
    logic [2:0] id_dst_reg;
    logic       id_dst_valid;
    logic [1:0] id_fwd_lat;
    logic [1:0] id_wb_lat;
    logic       pipe_hold;
    logic       redirect;
    logic       stall_decode;
    logic       flush_fetch;
    logic [7:0] busy_map;
    logic [PERF_W-1:0] stall_count;

    int vectors = 0;
    int miscompares = 0;

    hazard_scoreboard #(
        .NUM_REGS(8), .REG_W(3), .NUM_SRC(3), .CNT_W(2), .PERF_W(PERF_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_reg(id_src_reg),
        .id_src_valid(id_src_valid), .id_src_early(id_src_early),
        .id_dst_reg(id_dst_reg), .id_dst_valid(id_dst_valid),
        .id_fwd_lat(id_fwd_lat), .id_wb_lat(id_wb_lat), .pipe_hold(pipe_hold),
        .redirect(redirect), .stall_decode(stall_decode), .flush_fetch(flush_fetch),
        .busy_map(busy_map), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [8:0] srcs, input logic [2:0] sv,
                         input logic [2:0] se, input logic [2:0] dst, input logic dv,
                         input logic [1:0] fl, input logic [1:0] wl);
        id_valid = v; id_src_reg = srcs; id_src_valid = sv; id_src_early = se;
        id_dst_reg = dst; id_dst_valid = dv; id_fwd_lat = fl; id_wb_lat = wl;
    endtask

    task automatic idle();
        drive(1'b0, 9'd0, 3'b000, 3'b000, 3'd0, 1'b0, 2'd0, 2'd0);
        pipe_hold = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (busy_map !== 8'h00) begin miscompares++; $display("FAIL reset_busy: got %h expected %h", busy_map, 8'h00); end
        vectors++; if (stall_decode !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b expected %b", stall_decode, 1'b0); end
        vectors++; if (flush_fetch !== 1'b0) begin miscompares++; $display("FAIL reset_flush: got %b expected %b", flush_fetch, 1'b0); end
        vectors++; if (stall_count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected %0d", stall_count, 0); end
        tick();
        rst_n = 1'b1;
    endtask

    // ld r3 (fwd1, wb2); add r1,r3,r4 stalls exactly one cycle
    task automatic test_load_use();
        do_reset();
        drive(1'b1, {3'd0, 3'd0, 3'd0}, 3'b000, 3'b000, 3'd3, 1'b1, 2'd1, 2'd2);
        #1;
        vectors++; if (stall_decode !== 1'b0) begin miscompares++; $display("FAIL lu_ld_stall: got %b expected %b", stall_decode, 1'b0); end
        tick();
        drive(1'b1, {3'd0, 3'd4, 3'd3}, 3'b011, 3'b000, 3'd1, 1'b1, 2'd0, 2'd2);
        #1;
        vectors++; if (stall_decode !== 1'b1) begin miscompares++; $display("FAIL lu_stall: got %b expected %b", stall_decode, 1'b1); end
        tick();
        vectors++; if (stall_count !== 4'd1) begin miscompares++; $display("FAIL lu_count: got %0d expected %0d", stall_count, 1); end
        #1;
        vectors++; if (stall_decode !== 1'b0) begin miscompares++; $display("FAIL lu_release: got %b expected %b", stall_decode, 1'b0); end
        tick();
        idle();
        vectors++; if (busy_map !== 8'h02) begin miscompares++; $display("FAIL lu_busy: got %h expected %h", busy_map, 8'h02); end
        vectors++; if (stall_count !== 4'd1) begin miscompares++; $display("FAIL lu_count_end: got %0d expected %0d", stall_count, 1); end
    endtask

    // add r2 (fwd0, wb2): early reader stalls 2 cycles, non-early reader none
    task automatic test_early_branch();
        int stalls;
        do_reset();
        drive(1'b1, 9'd0, 3'b000, 3'b000, 3'd2, 1'b1, 2'd0, 2'd2);
        tick();
        drive(1'b1, {3'd0, 3'd0, 3'd2}, 3'b001, 3'b001, 3'd0, 1'b0, 2'd0, 2'd0);
        stalls = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (stall_decode === 1'b1) stalls++;
            else break;
            tick();
        end
        vectors++; if (stalls !== 2) begin miscompares++; $display("FAIL br_stalls: got %0d expected %0d", stalls, 2); end
        tick();
        vectors++; if (stall_count !== 4'd2) begin miscompares++; $display("FAIL br_count: got %0d expected %0d", stall_count, 2); end

        do_reset();
        drive(1'b1, 9'd0, 3'b000, 3'b000, 3'd2, 1'b1, 2'd0, 2'd2);
        tick();
        drive(1'b1, {3'd0, 3'd0, 3'd2}, 3'b001, 3'b000, 3'd0, 1'b0, 2'd0, 2'd0);
        #1;
        vectors++; if (stall_decode !== 1'b0) begin miscompares++; $display("FAIL br_late_stall: got %b expected %b", stall_decode, 1'b0); end
        tick();
        idle();
        vectors++; if (stall_count !== 4'd0) begin miscompares++; $display("FAIL br_late_count: got %0d expected %0d", stall_count, 0); end
    endtask

    // jal (r7, wb2) then jr r7: two stalls with r7 busy, then clear
    task automatic test_jal_jr();
        do_reset();
        drive(1'b1, 9'd0, 3'b000, 3'b000, 3'd7, 1'b1, 2'd0, 2'd2);
        tick();
        drive(1'b1, {3'd0, 3'd0, 3'd7}, 3'b001, 3'b001, 3'd0, 1'b0, 2'd0, 2'd0);
        for (int c = 0; c < 2; c++) begin
            #1;
            vectors++; if (stall_decode !== 1'b1) begin miscompares++; $display("FAIL jr_stall%0d: got %b expected %b", c, stall_decode, 1'b1); end
            vectors++; if (busy_map !== 8'h80) begin miscompares++; $display("FAIL jr_busy%0d: got %h expected %h", c, busy_map, 8'h80); end
            tick();
        end
        #1;
        vectors++; if (stall_decode !== 1'b0) begin miscompares++; $display("FAIL jr_release: got %b expected %b", stall_decode, 1'b0); end
        vectors++; if (busy_map !== 8'h00) begin miscompares++; $display("FAIL jr_busy_clear: got %h expected %h", busy_map, 8'h00); end
        tick();
        idle();
    endtask

    // redirect overrides a live hazard and the squashed writer loads nothing
    task automatic test_redirect();
        do_reset();
        drive(1'b1, 9'd0, 3'b000, 3'b000, 3'd3, 1'b1, 2'd1, 2'd2);
        tick();
        drive(1'b1, {3'd0, 3'd4, 3'd3}, 3'b011, 3'b000, 3'd1, 1'b1, 2'd0, 2'd2);
        redirect = 1'b1;
        #1;
        vectors++; if (flush_fetch !== 1'b1) begin miscompares++; $display("FAIL rd_flush: got %b expected %b", flush_fetch, 1'b1); end
        vectors++; if (stall_decode !== 1'b0) begin miscompares++; $display("FAIL rd_stall: got %b expected %b", stall_decode, 1'b0); end
        tick();
        idle();
        vectors++; if (busy_map !== 8'h08) begin miscompares++; $display("FAIL rd_busy: got %h expected %h", busy_map, 8'h08); end
        vectors++; if (stall_count !== 4'd0) begin miscompares++; $display("FAIL rd_count: got %0d expected %0d", stall_count, 0); end
    endtask

    // load-use stall while pipe_hold freezes counters for 3 cycles
    task automatic test_pipe_hold();
        do_reset();
        drive(1'b1, 9'd0, 3'b000, 3'b000, 3'd3, 1'b1, 2'd1, 2'd2);
        tick();
        drive(1'b1, {3'd0, 3'd4, 3'd3}, 3'b011, 3'b000, 3'd1, 1'b1, 2'd0, 2'd2);
        pipe_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++; if (stall_decode !== 1'b1) begin miscompares++; $display("FAIL ph_stall%0d: got %b expected %b", c, stall_decode, 1'b1); end
            tick();
            vectors++; if (stall_count !== 4'd0) begin miscompares++; $display("FAIL ph_count%0d: got %0d expected %0d", c, stall_count, 0); end
        end
        vectors++; if (busy_map !== 8'h08) begin miscompares++; $display("FAIL ph_busy: got %h expected %h", busy_map, 8'h08); end
        pipe_hold = 1'b0;
        #1;
        vectors++; if (stall_decode !== 1'b1) begin miscompares++; $display("FAIL ph_stall_after: got %b expected %b", stall_decode, 1'b1); end
        tick();
        vectors++; if (stall_count !== 4'd1) begin miscompares++; $display("FAIL ph_count_after: got %0d expected %0d", stall_count, 1); end
        #1;
        vectors++; if (stall_decode !== 1'b0) begin miscompares++; $display("FAIL ph_release: got %b expected %b", stall_decode, 1'b0); end
        tick();
        idle();
    endtask

    // younger writer overwrites an in-flight countdown; self-dependency never stalls
    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 9'd0, 3'b000, 3'b000, 3'd3, 1'b1, 2'd3, 2'd3);
        tick();
        drive(1'b1, {3'd0, 3'd0, 3'd4}, 3'b001, 3'b000, 3'd3, 1'b1, 2'd0, 2'd2);
        tick();
        drive(1'b1, {3'd0, 3'd0, 3'd3}, 3'b001, 3'b000, 3'd0, 1'b0, 2'd0, 2'd0);
        #1;
        vectors++; if (stall_decode !== 1'b0) begin miscompares++; $display("FAIL bb_overwrite: got %b expected %b", stall_decode, 1'b0); end
        tick();
        drive(1'b1, {3'd0, 3'd0, 3'd3}, 3'b001, 3'b001, 3'd0, 1'b0, 2'd0, 2'd0);
        #1;
        vectors++; if (stall_decode !== 1'b1) begin miscompares++; $display("FAIL bb_early: got %b expected %b", stall_decode, 1'b1); end
        tick();
        #1;
        vectors++; if (stall_decode !== 1'b0) begin miscompares++; $display("FAIL bb_early_rel: got %b expected %b", stall_decode, 1'b0); end
        tick();
        drive(1'b1, {3'd0, 3'd6, 3'd6}, 3'b011, 3'b000, 3'd6, 1'b1, 2'd1, 2'd2);
        #1;
        vectors++; if (stall_decode !== 1'b0) begin miscompares++; $display("FAIL bb_self: got %b expected %b", stall_decode, 1'b0); end
        tick();
        drive(1'b1, {3'd0, 3'd0, 3'd6}, 3'b001, 3'b000, 3'd0, 1'b0, 2'd0, 2'd0);
        id_valid = 1'b0;
        #1;
        vectors++; if (stall_decode !== 1'b0) begin miscompares++; $display("FAIL bb_invalid: got %b expected %b", stall_decode, 1'b0); end
        vectors++; if (busy_map !== 8'h40) begin miscompares++; $display("FAIL bb_busy: got %h expected %h", busy_map, 8'h40); end
        tick();
        idle();
    endtask

    // max latency 3 gives 3 stalls per round; 6 rounds saturate the 4-bit counter at 15
    task automatic test_count_saturation();
        int stalls;
        int exp_cnt;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 9'd0, 3'b000, 3'b000, 3'd3, 1'b1, 2'd3, 2'd3);
            tick();
            drive(1'b1, {3'd0, 3'd0, 3'd3}, 3'b001, 3'b000, 3'd0, 1'b0, 2'd0, 2'd0);
            stalls = 0;
            for (int c = 0; c < 8; c++) begin
                #1;
                if (stall_decode === 1'b1) stalls++;
                else break;
                tick();
            end
            tick();
            exp_cnt = (3 * (k + 1) > 15) ? 15 : 3 * (k + 1);
            vectors++; if (stalls !== 3) begin miscompares++; $display("FAIL sat_stalls%0d: got %0d expected %0d", k, stalls, 3); end
            vectors++; if (stall_count !== exp_cnt[PERF_W-1:0]) begin miscompares++; $display("FAIL sat_count%0d: got %0d expected %0d", k, stall_count, exp_cnt); end
        end
        idle();
    endtask

    // asynchronous reset in the middle of a countdown (wb_cnt[r5]=2)
    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 9'd0, 3'b000, 3'b000, 3'd5, 1'b1, 2'd1, 2'd3);
        tick();
        drive(1'b1, {3'd0, 3'd0, 3'd5}, 3'b001, 3'b001, 3'd0, 1'b0, 2'd0, 2'd0);
        tick();
        vectors++; if (stall_count !== 4'd1) begin miscompares++; $display("FAIL ar_count_pre: got %0d expected %0d", stall_count, 1); end
        vectors++; if (busy_map !== 8'h20) begin miscompares++; $display("FAIL ar_busy_pre: got %h expected %h", busy_map, 8'h20); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (busy_map !== 8'h00) begin miscompares++; $display("FAIL ar_busy: got %h expected %h", busy_map, 8'h00); end
        vectors++; if (stall_decode !== 1'b0) begin miscompares++; $display("FAIL ar_stall: got %b expected %b", stall_decode, 1'b0); end
        vectors++; if (stall_count !== 4'd0) begin miscompares++; $display("FAIL ar_count: got %0d expected %0d", stall_count, 0); end
        tick();
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_early_branch();
        test_jal_jr();
        test_redirect();
        test_pipe_hold();
        test_back_to_back();
        test_count_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
